vector_lsu: RTL and testbench
=============================

Name: vector_lsu

Overview:
- Vector load/store sequencer downstream of the core's Execute stage, between core and word-wide memory.
- Core hands over one command (base address, element count, direction, store vector); block issues sequential 16-bit accesses.
- Load: assembles returned words into a 256-bit vector. Store: slices the captured vector onto dataOut.
- Replaces the core's per-cycle Load/Store loops; core waits on busy/done.

Parameters:
ELEMS, 16, vector lanes
WORD_W, 16, lane and memory word width
ADDR_W, 16, memory address width

Ports:
Clk1  in  1  sole clock, rising edge
Reset  in  1  synchronous reset, active-high
start  in  1  command strobe, accepted only in IDLE
is_store  in  1  1 = store, 0 = load (sampled with start)
base_addr  in  16  first element address (sampled with start)
count  in  4  element count minus one; 0..15 -> 1..16 elements (sampled)
st_vector  in  256  store data, lane i = bits [16i+15:16i] (sampled)
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
ld_vector  out  256  assembled load result, stable from done until next accepted start
Addr  out  16  memory address
RD  out  1  read request
WR  out  1  write request
dataOut  out  16  store word
MemWait  in  1  memory stall; request presented this cycle not accepted
DataIn  in  16  read data, valid one cycle after an accepted read

Behaviour:
- Reset (sync, any state including mid-command): next edge -> state IDLE; busy, done, RD, WR = 0; Addr, dataOut, ld_vector = 0; issue/capture counters = 0; in-flight read data discarded.
- States: IDLE, LD_ISSUE, LD_DRAIN, ST_ISSUE, FINISH.
- IDLE: start=1 at edge k -> latch is_store, base_addr, count, st_vector; clear ld_vector; busy=1 from cycle k+1; next = ST_ISSUE or LD_ISSUE. start while busy ignored.
- Address: element i at base_addr + i, mod 2^16. 0xFFFF wraps to 0x0000.
- LD_ISSUE: RD=1, Addr=base+issue_idx.
  - Request accepted when RD & ~MemWait; issue_idx increments on acceptance.
  - On acceptance of idx == count -> LD_DRAIN.
  - MemWait=1 holds Addr/RD unchanged.
- Read capture (any load state): pend flag registered as (RD & ~MemWait).
  - When pend=1, DataIn written into lane cap_idx; cap_idx increments.
  - MemWait does not affect capture of an already-accepted read.
- LD_DRAIN: RD=0; after final lane captured -> FINISH.
- ST_ISSUE: WR=1, Addr=base+idx, dataOut=lane idx of latched vector.
  - idx increments on ~MemWait.
  - Accepted write of idx == count -> FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, RD=WR=0 -> IDLE. A start in FINISH is ignored.
- Unused lanes (index > count) of ld_vector read as 0.
- Latency, no stalls, N = count+1, start at edge k:
  - Load: reads on cycles k+1..k+N; done high in cycle k+N+2.
  - Store: writes on cycles k+1..k+N; done high in cycle k+N+1.
  - Each MemWait cycle adds exactly one cycle.
- RD and WR are never both 1. Outside an issue state, Addr and dataOut hold their last value.

Decomposition:
- Shared package cvp14_pkg: state encoding; ELEMS, WORD_W, ADDR_W constants; core opcode constants VLD=4'b0100 and VST=4'b0101, which the core uses to raise start/is_store.
- One natural sub-module: lane_mux, 16:1 word select for store slicing. Load lane write uses an indexed part-select in the top level.

Test Plan:
- Load 16, no stalls: base 0x0100, count 15, mem[0x100+i]=0x1000+i -> RD on 16 consecutive cycles, done at k+18, ld_vector lane i = 0x1000+i.
- Store 4 with stall: base 0x0200, count 3, st_vector lanes 0xA0..0xA3, MemWait=1 during 2nd write -> WR held at Addr 0x0201 for 2 cycles; writes 0x0200..0x0203 = 0xA0..0xA3; done at k+6.
- Address wrap: load base 0xFFFE, count 3 -> Addr sequence FFFE, FFFF, 0000, 0001; lanes 4..15 = 0.
- Single element: store count 0, base 0x0040, lane0 0xBEEF -> one WR cycle with dataOut=0xBEEF; done next cycle.
- Busy-ignore: start re-asserted with different base during load and in the FINISH cycle -> first command completes unaltered, no extra accesses.
- Reset mid-load after 5 reads -> next cycle RD=0, busy=0, ld_vector=0. A new load afterward starts at its own base, with no stale capture.

Source files
------------

// File: rtl/cvp14_pkg.sv
// Shared constants, state encoding and core opcodes for the vector load/store sequencer.
package cvp14_pkg;

   localparam int ELEMS  = 16;
   localparam int WORD_W = 16;
   localparam int ADDR_W = 16;
   localparam int IDX_W  = $clog2(ELEMS);
   localparam int VEC_W  = ELEMS * WORD_W;

   // Core opcodes that raise start (and is_store for VST)
   localparam logic [3:0] VLD = 4'b0100;
   localparam logic [3:0] VST = 4'b0101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_ISSUE,
      S_LD_DRAIN,
      S_ST_ISSUE,
      S_FINISH
   } state_t;

endpackage

// File: rtl/lane_mux.sv
// 16:1 word select used to slice the latched store vector onto the memory bus.
module lane_mux
   import cvp14_pkg::*;
(
   input  logic [VEC_W-1:0]  vec,
   input  logic [IDX_W-1:0]  sel,
   output logic [WORD_W-1:0] word
);

   assign word = vec[sel*WORD_W +: WORD_W];

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store sequencer: turns one core command into up to 16 sequential
// word accesses, assembling loads into a 256-bit vector.
module vector_lsu
   import cvp14_pkg::*;
(
   input  logic              Clk1,
   input  logic              Reset,
   input  logic              start,
   input  logic              is_store,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [IDX_W-1:0]  count,
   input  logic [VEC_W-1:0]  st_vector,
   output logic              busy,
   output logic              done,
   output logic [VEC_W-1:0]  ld_vector,
   output logic [ADDR_W-1:0] Addr,
   output logic              RD,
   output logic              WR,
   output logic [WORD_W-1:0] dataOut,
   input  logic              MemWait,
   input  logic [WORD_W-1:0] DataIn
);

   state_t              state, state_next;
   logic [ADDR_W-1:0]   base_q;
   logic [IDX_W-1:0]    count_q;
   logic [VEC_W-1:0]    st_vec_q;
   logic [IDX_W-1:0]    issue_idx;
   logic [IDX_W-1:0]    cap_idx;
   logic                pend;
   logic [ADDR_W-1:0]   addr_hold;
   logic [WORD_W-1:0]   data_hold;
   logic [ADDR_W-1:0]   issue_addr;
   logic [WORD_W-1:0]   lane_word;
   logic                accept;

   assign issue_addr = base_q + {{(ADDR_W-IDX_W){1'b0}}, issue_idx};
   assign accept     = (RD | WR) & ~MemWait;

   lane_mux u_lane_mux (
      .vec  (st_vec_q),
      .sel  (issue_idx),
      .word (lane_word)
   );

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      RD         = 1'b0;
      WR         = 1'b0;
      Addr       = addr_hold;
      dataOut    = data_hold;
      case (state)
         S_IDLE: begin
            if (start) state_next = is_store ? S_ST_ISSUE : S_LD_ISSUE;
         end
         S_LD_ISSUE: begin
            busy = 1'b1;
            RD   = 1'b1;
            Addr = issue_addr;
            if (!MemWait && issue_idx == count_q) state_next = S_LD_DRAIN;
         end
         S_LD_DRAIN: begin
            busy = 1'b1;
            if (pend && cap_idx == count_q) state_next = S_FINISH;
         end
         S_ST_ISSUE: begin
            busy    = 1'b1;
            WR      = 1'b1;
            Addr    = issue_addr;
            dataOut = lane_word;
            if (!MemWait && issue_idx == count_q) state_next = S_FINISH;
         end
         S_FINISH: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk1) begin
      if (Reset) begin
         state     <= S_IDLE;
         issue_idx <= '0;
         cap_idx   <= '0;
         pend      <= 1'b0;
         ld_vector <= '0;
         addr_hold <= '0;
         data_hold <= '0;
      end else begin
         state <= state_next;
         pend  <= RD & ~MemWait;
         if (RD | WR) begin
            addr_hold <= Addr;
            data_hold <= dataOut;
         end
         if (accept) issue_idx <= issue_idx + 1'b1;
         // Read data arrives the cycle after acceptance, regardless of MemWait
         if (pend) begin
            ld_vector[cap_idx*WORD_W +: WORD_W] <= DataIn;
            cap_idx <= cap_idx + 1'b1;
         end
         if (state == S_IDLE && start) begin
            issue_idx <= '0;
            cap_idx   <= '0;
            ld_vector <= '0;
         end
      end
   end

   always_ff @(posedge Clk1) begin
      if (state == S_IDLE && start) begin
         base_q   <= base_addr;
         count_q  <= count;
         st_vec_q <= st_vector;
      end
   end

endmodule

// File: tb/tb_vector_lsu.sv
// Directed bench for vector_lsu: memory model, access logging and per-scenario checks.
module tb_vector_lsu;

   logic          Clk1 = 1'b0;
   logic          Reset = 1'b1;
   logic          start = 1'b0;
   logic          is_store = 1'b0;
   logic [15:0]   base_addr = '0;
   logic [3:0]    count = '0;
   logic [255:0]  st_vector = '0;
   logic          busy, done;
   logic [255:0]  ld_vector;
   logic [15:0]   Addr;
   logic          RD, WR;
   logic [15:0]   dataOut;
   logic          MemWait = 1'b0;
   logic [15:0]   DataIn = '0;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:65535];
   logic [15:0] nxt_rd;
   int          ncyc = 0;
   int          k_neg = 0;
   int          overlap = 0;
   int          rd_cyc[$];
   logic [15:0] rd_addr[$];
   int          rd_acc = 0;
   int          wr_cyc[$];
   logic [15:0] wr_addr[$];
   logic [15:0] wr_data[$];
   int          done_cyc[$];

   vector_lsu dut (
      .Clk1      (Clk1),
      .Reset     (Reset),
      .start     (start),
      .is_store  (is_store),
      .base_addr (base_addr),
      .count     (count),
      .st_vector (st_vector),
      .busy      (busy),
      .done      (done),
      .ld_vector (ld_vector),
      .Addr      (Addr),
      .RD        (RD),
      .WR        (WR),
      .dataOut   (dataOut),
      .MemWait   (MemWait),
      .DataIn    (DataIn)
   );

   always #5 Clk1 = ~Clk1;

   // Word memory: sampled mid-cycle, read data presented just after the next edge
   always @(negedge Clk1) begin
      ncyc++;
      nxt_rd = 16'hDEAD;
      if (start && !busy && !done && !Reset) k_neg = ncyc;
      if (RD && WR) overlap++;
      if (RD) begin
         rd_cyc.push_back(ncyc - k_neg);
         rd_addr.push_back(Addr);
      end
      if (RD && !MemWait) begin
         nxt_rd = mem[Addr];
         rd_acc++;
      end
      if (WR) begin
         wr_cyc.push_back(ncyc - k_neg);
         wr_addr.push_back(Addr);
         wr_data.push_back(dataOut);
      end
      if (WR && !MemWait) mem[Addr] = dataOut;
      if (done) done_cyc.push_back(ncyc - k_neg);
      @(posedge Clk1);
      #1 DataIn = nxt_rd;
   end

   task automatic clear_log();
      rd_cyc.delete();
      rd_addr.delete();
      wr_cyc.delete();
      wr_addr.delete();
      wr_data.delete();
      done_cyc.delete();
      overlap = 0;
      rd_acc = 0;
   endtask

   task automatic issue_cmd(input logic st, input logic [15:0] base, input logic [3:0] cnt);
      is_store  = st;
      base_addr = base;
      count     = cnt;
      start     = 1'b1;
      @(posedge Clk1);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge Clk1);
         if (done === 1'b1) seen = 1'b1;
      end
      @(posedge Clk1);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) @(posedge Clk1);
      #1 Reset = 1'b0;
      checks++;
      if ({busy, done, RD, WR} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: busy/done/RD/WR=%b expected 0000", {busy, done, RD, WR});
      end
      checks++;
      if (Addr !== 16'h0 || dataOut !== 16'h0) begin
         errors++;
         $display("FAIL reset_bus: Addr=%h dataOut=%h expected 0000/0000", Addr, dataOut);
      end
      checks++;
      if (ld_vector !== 256'h0) begin
         errors++;
         $display("FAIL reset_ldvec: ld_vector=%h expected 0", ld_vector);
      end
   endtask

   task automatic test_load16();
      bit seen;
      for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 16'h1000 + 16'(i);
      clear_log();
      issue_cmd(1'b0, 16'h0100, 4'd15);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL load16_busy: busy=%b expected 1", busy);
      end
      wait_done(40, seen);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL load16_timeout: done=0 expected a done pulse within 40 cycles");
      end
      checks++;
      if (rd_cyc.size() != 16 || rd_acc != 16 || wr_cyc.size() != 0) begin
         errors++;
         $display("FAIL load16_count: rd=%0d acc=%0d wr=%0d expected 16/16/0",
                  rd_cyc.size(), rd_acc, wr_cyc.size());
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (i >= rd_cyc.size() || rd_cyc[i] != i + 1 || rd_addr[i] !== 16'h0100 + 16'(i)) begin
            errors++;
            $display("FAIL load16_rd%0d: read slot missing or wrong cycle/addr, expected cycle k+%0d addr %h",
                     i, i + 1, 16'h0100 + 16'(i));
         end
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != 18) begin
         errors++;
         $display("FAIL load16_done: done pulses=%0d first at k+%0d expected one at k+18",
                  done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (ld_vector[i*16 +: 16] !== 16'h1000 + 16'(i)) begin
            errors++;
            $display("FAIL load16_lane%0d: got %h expected %h", i, ld_vector[i*16 +: 16], 16'h1000 + 16'(i));
         end
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL load16_idle: busy=%b done=%b expected 0/0", busy, done);
      end
   endtask

   task automatic test_store_stall();
      bit seen;
      logic [15:0] ea [5] = '{16'h0200, 16'h0201, 16'h0201, 16'h0202, 16'h0203};
      logic [15:0] ed [5] = '{16'h00A0, 16'h00A1, 16'h00A1, 16'h00A2, 16'h00A3};
      st_vector = {16{16'h5555}};
      for (int i = 0; i < 4; i++) begin
         st_vector[i*16 +: 16] = 16'h00A0 + 16'(i);
         mem[16'h0200 + i] = 16'h0000;
      end
      clear_log();
      issue_cmd(1'b1, 16'h0200, 4'd3);
      @(posedge Clk1);
      #1 MemWait = 1'b1;
      @(posedge Clk1);
      #1 MemWait = 1'b0;
      wait_done(20, seen);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL store_timeout: done=0 expected a done pulse within 20 cycles");
      end
      checks++;
      if (wr_cyc.size() != 5 || rd_cyc.size() != 0) begin
         errors++;
         $display("FAIL store_count: wr cycles=%0d rd=%0d expected 5/0", wr_cyc.size(), rd_cyc.size());
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= wr_cyc.size() || wr_cyc[i] != i + 1 || wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) begin
            errors++;
            $display("FAIL store_wr%0d: write slot missing or wrong, expected cycle k+%0d addr %h data %h",
                     i, i + 1, ea[i], ed[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[16'h0200 + i] !== 16'h00A0 + 16'(i)) begin
            errors++;
            $display("FAIL store_mem%0d: got %h expected %h", i, mem[16'h0200 + i], 16'h00A0 + 16'(i));
         end
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != 6) begin
         errors++;
         $display("FAIL store_done: done pulses=%0d first at k+%0d expected one at k+6",
                  done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
   endtask

   task automatic test_wrap();
      bit seen;
      logic [15:0] ea [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      logic [15:0] ev [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      for (int i = 0; i < 4; i++) mem[ea[i]] = ev[i];
      clear_log();
      issue_cmd(1'b0, 16'hFFFE, 4'd3);
      wait_done(20, seen);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL wrap_timeout: done=0 expected a done pulse within 20 cycles");
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= rd_addr.size() || rd_addr[i] !== ea[i] || ld_vector[i*16 +: 16] !== ev[i]) begin
            errors++;
            $display("FAIL wrap_el%0d: addr/lane wrong, lane=%h expected addr %h lane %h",
                     i, ld_vector[i*16 +: 16], ea[i], ev[i]);
         end
      end
      checks++;
      if (ld_vector[255:64] !== 192'h0) begin
         errors++;
         $display("FAIL wrap_upper: lanes 4..15=%h expected 0", ld_vector[255:64]);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != 6 || rd_cyc.size() != 4) begin
         errors++;
         $display("FAIL wrap_timing: done pulses=%0d reads=%0d expected done at k+6 after 4 reads",
                  done_cyc.size(), rd_cyc.size());
      end
   endtask

   task automatic test_single();
      bit seen;
      st_vector = {16{16'h7777}};
      st_vector[15:0] = 16'hBEEF;
      clear_log();
      issue_cmd(1'b1, 16'h0040, 4'd0);
      wait_done(10, seen);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL single_timeout: done=0 expected a done pulse within 10 cycles");
      end
      checks++;
      if (wr_cyc.size() != 1 || wr_cyc[0] != 1 || wr_addr[0] !== 16'h0040 || wr_data[0] !== 16'hBEEF) begin
         errors++;
         $display("FAIL single_wr: writes=%0d expected exactly one at k+1 addr 0040 data BEEF", wr_cyc.size());
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != 2) begin
         errors++;
         $display("FAIL single_done: done pulses=%0d expected one at k+2", done_cyc.size());
      end
      checks++;
      if (Addr !== 16'h0040 || dataOut !== 16'hBEEF || WR !== 1'b0) begin
         errors++;
         $display("FAIL single_hold: Addr=%h dataOut=%h WR=%b expected 0040/BEEF/0", Addr, dataOut, WR);
      end
   endtask

   task automatic test_busy_ignore();
      for (int i = 0; i < 4; i++) mem[16'h0300 + i] = 16'h3000 + 16'(i);
      clear_log();
      issue_cmd(1'b0, 16'h0300, 4'd3);
      @(posedge Clk1);
      #1;
      is_store  = 1'b1;
      base_addr = 16'h0500;
      count     = 4'd7;
      start     = 1'b1;
      @(posedge Clk1);
      #1 start = 1'b0;
      repeat (3) @(posedge Clk1);
      #1 start = 1'b1;
      @(posedge Clk1);
      #1 start = 1'b0;
      repeat (6) @(posedge Clk1);
      #1;
      checks++;
      if (rd_cyc.size() != 4 || wr_cyc.size() != 0) begin
         errors++;
         $display("FAIL busy_ignore_acc: reads=%0d writes=%0d expected 4/0", rd_cyc.size(), wr_cyc.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= rd_addr.size() || rd_addr[i] !== 16'h0300 + 16'(i) || ld_vector[i*16 +: 16] !== 16'h3000 + 16'(i)) begin
            errors++;
            $display("FAIL busy_ignore_el%0d: lane=%h expected addr %h lane %h",
                     i, ld_vector[i*16 +: 16], 16'h0300 + 16'(i), 16'h3000 + 16'(i));
         end
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != 6 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignore_done: done pulses=%0d busy=%b expected one at k+6, busy 0",
                  done_cyc.size(), busy);
      end
   endtask

   task automatic test_reset_mid_load();
      bit seen;
      for (int i = 0; i < 16; i++) mem[16'h0400 + i] = 16'h4000 + 16'(i);
      mem[16'h0600] = 16'h6006;
      mem[16'h0601] = 16'h6116;
      clear_log();
      issue_cmd(1'b0, 16'h0400, 4'd15);
      repeat (4) @(posedge Clk1);
      #1 Reset = 1'b1;
      @(posedge Clk1);
      #1 Reset = 1'b0;
      checks++;
      if (RD !== 1'b0 || busy !== 1'b0 || ld_vector !== 256'h0 || Addr !== 16'h0) begin
         errors++;
         $display("FAIL midreset_state: RD=%b busy=%b Addr=%h ldvec_nonzero=%b expected 0/0/0000/0",
                  RD, busy, Addr, ld_vector != 256'h0);
      end
      checks++;
      if (rd_cyc.size() != 5) begin
         errors++;
         $display("FAIL midreset_reads: reads=%0d expected 5", rd_cyc.size());
      end
      clear_log();
      issue_cmd(1'b0, 16'h0600, 4'd1);
      wait_done(15, seen);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL midreset_timeout: done=0 expected a done pulse within 15 cycles");
      end
      checks++;
      if (rd_addr.size() != 2 || rd_addr[0] !== 16'h0600 || rd_addr[1] !== 16'h0601) begin
         errors++;
         $display("FAIL midreset_addr: reads=%0d expected 0600,0601", rd_addr.size());
      end
      checks++;
      if (ld_vector !== {224'h0, 16'h6116, 16'h6006}) begin
         errors++;
         $display("FAIL midreset_vec: ld_vector=%h expected lanes 6006,6116 then zeros", ld_vector);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != 4 || overlap != 0) begin
         errors++;
         $display("FAIL midreset_done: done pulses=%0d overlap=%0d expected one at k+4, overlap 0",
                  done_cyc.size(), overlap);
      end
   endtask

   initial begin
      test_reset();
      test_load16();
      test_store_stall();
      test_wrap();
      test_single();
      test_busy_ignore();
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
